// File: rtl/adc_serial_link.sv
// Round-robin ADC sequencer: mux settle, SOC/EOC handshake with timeout,
// then the captured sample is sent as an async serial frame gated by dsr.
module adc_serial_link #(
    parameter int DATA_W      = 8,
    parameter int NUM_CH      = 8,
    parameter int CH_W        = 4,
    parameter int BAUD_DIV    = 104,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int EOC_TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              eoc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dsr,
    output logic              mux_en,
    output logic [CH_W-1:0]   canale,
    output logic              soc,
    output logic              load_dato,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done,
    output logic              error
);

    localparam int FRAME_W = DATA_W + PARITY_EN + 2;
    localparam int TAIL_W  = FRAME_W - 1;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int BAUD_W  = $clog2(BAUD_DIV);
    localparam int TMO_W   = $clog2(EOC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        MUX,
        CONV,
        LOAD,
        TX
    } state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_canale;
    logic [TMO_W-1:0]    r_tmo;
    logic [BAUD_W-1:0]   r_baud;
    logic [BIT_W-1:0]    r_bit;
    logic [TAIL_W-1:0]   r_shift;
    logic                r_mux_en;
    logic                r_soc;
    logic                r_load;
    logic                r_dout;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic                w_parity;
    logic [TAIL_W-1:0]   w_tail;
    logic [CH_W-1:0]     w_next_ch;

    // Everything after the start bit: data MSB first, optional parity, stop.
    always_comb begin
        w_parity = (^data_in) ^ (PARITY_ODD != 0);
        w_tail   = '1;
        w_tail[TAIL_W-1 -: DATA_W] = data_in;
        if (PARITY_EN != 0) begin
            w_tail[1] = w_parity;
        end
        w_next_ch = (r_canale == CH_W'(NUM_CH - 1)) ? '0 : r_canale + CH_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_canale <= '0;
            r_tmo    <= '0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
            r_mux_en <= 1'b0;
            r_soc    <= 1'b0;
            r_load   <= 1'b0;
            r_dout   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tmo <= '0;
                    if (run) begin
                        r_state  <= MUX;
                        r_mux_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                MUX: begin
                    r_state <= CONV;
                    r_soc   <= 1'b1;
                end
                CONV: begin
                    if (eoc) begin
                        r_state  <= LOAD;
                        r_soc    <= 1'b0;
                        r_mux_en <= 1'b0;
                        r_load   <= 1'b1;
                    end else if (r_tmo == TMO_W'(EOC_TIMEOUT - 1)) begin
                        r_state  <= IDLE;
                        r_soc    <= 1'b0;
                        r_mux_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_error  <= 1'b1;
                        r_canale <= w_next_ch;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                LOAD: begin
                    r_load <= 1'b0;
                    if (dsr) begin
                        r_state <= TX;
                        r_shift <= w_tail;
                        r_dout  <= 1'b0;
                        r_baud  <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_error  <= 1'b1;
                        r_canale <= w_next_ch;
                    end
                end
                TX: begin
                    if (r_baud == BAUD_W'(BAUD_DIV - 1)) begin
                        r_baud <= '0;
                        // r_bit == TAIL_W means the bit just finished was the stop bit
                        if (r_bit == BIT_W'(TAIL_W)) begin
                            r_state  <= IDLE;
                            r_dout   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_error  <= 1'b0;
                            r_canale <= w_next_ch;
                        end else begin
                            r_dout  <= r_shift[TAIL_W-1];
                            r_shift <= {r_shift[TAIL_W-2:0], 1'b1};
                            r_bit   <= r_bit + BIT_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mux_en     = r_mux_en;
    assign canale     = r_canale;
    assign soc        = r_soc;
    assign load_dato  = r_load;
    assign data_out   = r_dout;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_adc_serial_link.sv
// Scoreboard bench for adc_serial_link: three instances (even parity, odd
// parity, no parity); expected events are queued by stimulus, popped by a monitor.
module tb_adc_serial_link;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       run_s [3];
    logic       eoc_s [3];
    logic [7:0] din   [3];
    logic       dsr_s [3];
    logic       mux_o [3];
    logic [3:0] ch_o  [3];
    logic       soc_o [3];
    logic       ld_o  [3];
    logic       dout  [3];
    logic       busy_o[3];
    logic       fd_o  [3];
    logic       err_o [3];

    adc_serial_link #(.DATA_W(8), .NUM_CH(3), .CH_W(4), .BAUD_DIV(4), .PARITY_EN(1),
                      .PARITY_ODD(0), .EOC_TIMEOUT(10)) u_even (
        .clock(clk), .reset(rst), .run(run_s[0]), .eoc(eoc_s[0]), .data_in(din[0]),
        .dsr(dsr_s[0]), .mux_en(mux_o[0]), .canale(ch_o[0]), .soc(soc_o[0]),
        .load_dato(ld_o[0]), .data_out(dout[0]), .busy(busy_o[0]),
        .frame_done(fd_o[0]), .error(err_o[0]));

    adc_serial_link #(.DATA_W(8), .NUM_CH(3), .CH_W(4), .BAUD_DIV(4), .PARITY_EN(1),
                      .PARITY_ODD(1), .EOC_TIMEOUT(10)) u_odd (
        .clock(clk), .reset(rst), .run(run_s[1]), .eoc(eoc_s[1]), .data_in(din[1]),
        .dsr(dsr_s[1]), .mux_en(mux_o[1]), .canale(ch_o[1]), .soc(soc_o[1]),
        .load_dato(ld_o[1]), .data_out(dout[1]), .busy(busy_o[1]),
        .frame_done(fd_o[1]), .error(err_o[1]));

    adc_serial_link #(.DATA_W(8), .NUM_CH(3), .CH_W(4), .BAUD_DIV(4), .PARITY_EN(0),
                      .PARITY_ODD(0), .EOC_TIMEOUT(10)) u_nopar (
        .clock(clk), .reset(rst), .run(run_s[2]), .eoc(eoc_s[2]), .data_in(din[2]),
        .dsr(dsr_s[2]), .mux_en(mux_o[2]), .canale(ch_o[2]), .soc(soc_o[2]),
        .load_dato(ld_o[2]), .data_out(dout[2]), .busy(busy_o[2]),
        .frame_done(fd_o[2]), .error(err_o[2]));

    // kind: 0 = frame, 1 = dsr refused at LOAD, 2 = conversion timeout
    typedef struct {
        int u;
        int kind;
        int ch;
        int bits;
        int nbits;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   delay[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int u, input int kind, input int ch, input int bits, input int nb);
        exp_t e;
        e.u = u; e.kind = kind; e.ch = ch; e.bits = bits; e.nbits = nb;
        q.push_back(e);
    endtask

    task automatic pop(input int u, input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (q.size() == 0) begin
            chk("unexpected_event", kind * 4 + u, -1);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind * 4 + u, e.kind * 4 + e.u);
            ok = (e.kind == kind) && (e.u == u);
        end
    endtask

    // ADC model: eoc rises once soc has been high for delay[u] cycles (0 = never)
    int acnt[3];
    initial begin
        for (int u = 0; u < 3; u++) begin acnt[u] = 0; eoc_s[u] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                if (soc_o[u]) acnt[u]++;
                else acnt[u] = 0;
                eoc_s[u] = (delay[u] != 0) && (acnt[u] >= delay[u]);
            end
        end
    end

    logic m_buf [3][64];
    int   m_n   [3];
    int   m_ch  [3];
    int   m_soc [3];
    int   m_sch [3];
    bit   m_cap [3];
    bit   m_post[3];

    task automatic check_frame(input int u, input exp_t e);
        int dec;
        int hold_ok;
        dec = 0;
        hold_ok = 1;
        chk("tx_cycles", m_n[u], e.nbits * 4);
        for (int b = 0; b < e.nbits; b++) begin
            dec = dec * 2 + int'(m_buf[u][b*4]);
            for (int c = 1; c < 4; c++)
                if (m_buf[u][b*4+c] !== m_buf[u][b*4]) hold_ok = 0;
        end
        chk("frame_bits", dec, e.bits);
        chk("bit_hold", hold_ok, 1);
        chk("frame_ch", m_ch[u], e.ch);
        chk("done_err", int'(err_o[u]), 0);
    endtask

    initial begin
        exp_t e;
        bit   ok;
        for (int u = 0; u < 3; u++) begin
            m_n[u] = 0; m_ch[u] = 0; m_soc[u] = 0; m_sch[u] = 0; m_cap[u] = 0; m_post[u] = 0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 3; u++) begin
                if (rst) begin
                    m_cap[u] = 0; m_post[u] = 0; m_soc[u] = 0; m_n[u] = 0;
                end else begin
                    if (m_post[u]) begin
                        m_post[u] = 0;
                        if (!busy_o[u]) begin
                            pop(u, 1, e, ok);
                            if (ok) begin
                                chk("dsr_ch", m_ch[u], e.ch);
                                chk("dsr_err", int'(err_o[u]), 1);
                                chk("dsr_line", int'(dout[u]), 1);
                            end
                            m_cap[u] = 0;
                        end
                    end
                    if (m_cap[u]) begin
                        if (fd_o[u]) begin
                            pop(u, 0, e, ok);
                            if (ok) check_frame(u, e);
                            m_cap[u] = 0;
                        end else if (m_n[u] < 64) begin
                            m_buf[u][m_n[u]] = dout[u];
                            m_n[u]++;
                        end
                    end else if (fd_o[u]) begin
                        chk("spurious_done", 1, 0);
                    end
                    if (ld_o[u]) begin
                        m_cap[u] = 1; m_post[u] = 1; m_n[u] = 0; m_ch[u] = int'(ch_o[u]);
                    end
                    if (soc_o[u]) begin
                        if (m_soc[u] == 0) m_sch[u] = int'(ch_o[u]);
                        m_soc[u]++;
                    end else begin
                        if (m_soc[u] > 0 && !ld_o[u]) begin
                            pop(u, 2, e, ok);
                            if (ok) begin
                                chk("tmo_soc_len", m_soc[u], e.nbits);
                                chk("tmo_ch", m_sch[u], e.ch);
                                chk("tmo_err", int'(err_o[u]), 1);
                                chk("tmo_busy", int'(busy_o[u]), 0);
                            end
                        end
                        m_soc[u] = 0;
                    end
                end
            end
        end
    end

    // Returns at the negedge after the LOAD cycle, so data_in/dsr may change safely.
    task automatic wait_load(input int u);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ld_o[u] && n < 300);
        chk("load_seen", int'(ld_o[u]), 1);
        @(negedge clk);
    endtask

    task automatic wait_drain(input int u);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q.size() != 0 || busy_o[u]) && n < 1000);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n;
        for (int u = 0; u < 3; u++) begin
            run_s[u] = 1'b0; dsr_s[u] = 1'b1; din[u] = 8'h00;
        end
        delay[0] = 2; delay[1] = 1; delay[2] = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("rst_mux_en", int'(mux_o[u]), 0);
            chk("rst_canale", int'(ch_o[u]), 0);
            chk("rst_soc", int'(soc_o[u]), 0);
            chk("rst_load", int'(ld_o[u]), 0);
            chk("rst_data_out", int'(dout[u]), 1);
            chk("rst_busy", int'(busy_o[u]), 0);
            chk("rst_done", int'(fd_o[u]), 0);
            chk("rst_error", int'(err_o[u]), 0);
        end
        #1 rst = 1'b0;
        @(negedge clk);

        // Even parity, channel wrap 0,1,2,0 over NUM_CH = 3
        din[0] = 8'hA5; push(0, 0, 0, 11'b0_10100101_0_1, 11); run_s[0] = 1'b1;
        wait_load(0);
        din[0] = 8'h3D; push(0, 0, 1, 11'b0_00111101_1_1, 11);
        wait_load(0);
        dsr_s[0] = 1'b0; push(0, 1, 2, 0, 0);
        wait_load(0);
        dsr_s[0] = 1'b1; din[0] = 8'hFF; push(0, 0, 0, 11'b0_11111111_0_1, 11);
        wait_load(0);

        // eoc never arrives on channel 1
        delay[0] = 0; push(0, 2, 1, 0, 10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(err_o[0] && !busy_o[0]) && n < 300);
        chk("tmo_seen", int'(err_o[0] && !busy_o[0]), 1);
        delay[0] = 2; din[0] = 8'h80;

        // Reset during the 4th data bit of the channel-2 frame
        wait_load(0);
        repeat (16) @(negedge clk);
        chk("pre_rst_line", int'(dout[0]), 0);
        chk("pre_rst_canale", int'(ch_o[0]), 2);
        #1 rst = 1'b1;
        #1;
        chk("midrst_data_out", int'(dout[0]), 1);
        chk("midrst_busy", int'(busy_o[0]), 0);
        chk("midrst_canale", int'(ch_o[0]), 0);
        chk("midrst_done", int'(fd_o[0]), 0);
        din[0] = 8'h07; push(0, 0, 0, 11'b0_00000111_1_1, 11);
        @(negedge clk);
        #1 rst = 1'b0;
        wait_load(0);
        run_s[0] = 1'b0;
        wait_drain(0);
        repeat (5) @(negedge clk);
        chk("park_busy", int'(busy_o[0]), 0);
        chk("park_canale", int'(ch_o[0]), 1);

        // Odd parity over 0x00, eoc already high on the first CONV cycle
        din[1] = 8'h00; push(1, 0, 0, 11'b0_00000000_1_1, 11); run_s[1] = 1'b1;
        wait_load(1);
        run_s[1] = 1'b0;
        wait_drain(1);

        // No parity: 10-bit frame
        din[2] = 8'hC3; push(2, 0, 0, 10'b0_11000011_1, 10); run_s[2] = 1'b1;
        wait_load(2);
        run_s[2] = 1'b0;
        wait_drain(2);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
